// File: rtl/adc_pkg.sv
// Shared types and constants for the SAR ADC conversion-start generator.
// Optional feature macro used by the top: ADC_EDGE_START_TIMEOUT_EN.
package adc_pkg;

    localparam int ADC_CNT_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_HIGH      = 2'd1;
    localparam state_t ST_WAIT_DONE = 2'd2;
    localparam state_t ST_GAP       = 2'd3;

endpackage

// File: rtl/adc_load_down_counter.sv
// Loadable down-counter; a zero load value is clamped to 1.
// tc_o flags the last counted cycle (count == 1).
module adc_load_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? W'(1) : load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == W'(1));

endmodule

// File: rtl/adc_edge_start_gen.sv
// Conversion-start edge generator for the SAR ADC (one-shot / free-running).
// Define ADC_EDGE_START_TIMEOUT_EN to build the done-wait timeout.
module adc_edge_start_gen
    import adc_pkg::*;
#(
    parameter int CNT_W          = ADC_CNT_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             continuous_i,
    input  logic             single_i,
    input  logic [CNT_W-1:0] high_cycles_i,
    input  logic [CNT_W-1:0] gap_cycles_i,
    input  logic             conv_done_i,
    input  logic             clear_i,
    output logic             start_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] start_count_o
);

    state_t           state_q, state_d;
    logic             start_q, start_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             dlat_q, dlat_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;

    logic             hi_load, hi_dec, hi_tc;
    logic             gap_load, gap_dec, gap_tc;
    logic [CNT_W-1:0] hi_cnt, gap_cnt;
    logic             busy;
    logic             wait_exit;

    assign busy = (state_q != ST_IDLE);

`ifdef ADC_EDGE_START_TIMEOUT_EN
    localparam int DW_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(TIMEOUT_CYCLES - 1);

    logic [DW_W-1:0] dwell_q, dwell_d;
    logic            to_q, to_d;
    logic            dwell_hit;

    assign dwell_hit = (dwell_q == DW_LAST);

    always_comb begin
        dwell_d = dwell_q;
        to_d    = clear_i ? 1'b0 : to_q;
        if (state_q != ST_WAIT_DONE) begin
            dwell_d = '0;
        end else if (!(conv_done_i || dlat_q)) begin
            if (dwell_hit) begin
                to_d = 1'b1;
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            to_q    <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            to_q    <= to_d;
        end
    end

    assign wait_exit = conv_done_i || dlat_q || dwell_hit;
    assign timeout_o = to_q;
`else
    assign wait_exit = conv_done_i || dlat_q;
    assign timeout_o = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        pend_d   = pend_q;
        ovr_d    = clear_i ? 1'b0 : ovr_q;
        dlat_d   = dlat_q;
        scnt_d   = scnt_q;
        hi_load  = 1'b0;
        hi_dec   = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;

        // A new overrun is applied after the clear so that set wins.
        if (single_i && busy) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i && (single_i || pend_q || continuous_i)) begin
                    state_d = ST_HIGH;
                    start_d = 1'b1;
                    hi_load = 1'b1;
                    scnt_d  = scnt_q + CNT_W'(1);
                    pend_d  = 1'b0;
                    dlat_d  = 1'b0;
                end
            end
            ST_HIGH: begin
                hi_dec = 1'b1;
                if (conv_done_i) begin
                    dlat_d = 1'b1;
                end
                if (hi_tc) begin
                    state_d = ST_WAIT_DONE;
                    start_d = 1'b0;
                end
            end
            ST_WAIT_DONE: begin
                if (wait_exit) begin
                    state_d  = ST_GAP;
                    gap_load = 1'b1;
                    dlat_d   = 1'b0;
                end
            end
            ST_GAP: begin
                gap_dec = 1'b1;
                if (gap_tc) begin
                    if (enable_i && (continuous_i || pend_q)) begin
                        state_d = ST_HIGH;
                        start_d = 1'b1;
                        hi_load = 1'b1;
                        scnt_d  = scnt_q + CNT_W'(1);
                        pend_d  = 1'b0;
                        dlat_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase

        if (!enable_i) begin
            state_d  = ST_IDLE;
            start_d  = 1'b0;
            pend_d   = 1'b0;
            dlat_d   = 1'b0;
            scnt_d   = scnt_q;
            hi_load  = 1'b0;
            gap_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            dlat_q  <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            dlat_q  <= dlat_d;
            scnt_q  <= scnt_d;
        end
    end

    adc_load_down_counter #(.W(CNT_W)) u_hi_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (hi_load),
        .load_val_i (high_cycles_i),
        .dec_i      (hi_dec),
        .cnt_o      (hi_cnt),
        .tc_o       (hi_tc)
    );

    adc_load_down_counter #(.W(CNT_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (gap_load),
        .load_val_i (gap_cycles_i),
        .dec_i      (gap_dec),
        .cnt_o      (gap_cnt),
        .tc_o       (gap_tc)
    );

    logic unused_cnt;
    assign unused_cnt = ^{hi_cnt, gap_cnt};

    assign start_o       = start_q;
    assign busy_o        = busy;
    assign overrun_o     = ovr_q;
    assign start_count_o = scnt_q;

endmodule

// File: tb/tb_adc_edge_start_gen.sv
// Self-checking bench for adc_edge_start_gen (CNT_W=4, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling edge.
module tb_adc_edge_start_gen;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, cont, single, done, clr;
    logic [W-1:0] hc, gc;
    logic         start, busy, ovr, tmo;
    logic [W-1:0] cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         en, cont, single, done, clr;
        logic [W-1:0] hc, gc;
        logic         s, b, o;
        logic [W-1:0] c;
    } vec_t;

    typedef struct {
        int           idx;
        logic         s, b, o;
        logic [W-1:0] c;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    adc_edge_start_gen #(.CNT_W(W), .TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (en),
        .continuous_i  (cont),
        .single_i      (single),
        .high_cycles_i (hc),
        .gap_cycles_i  (gc),
        .conv_done_i   (done),
        .clear_i       (clr),
        .start_o       (start),
        .busy_o        (busy),
        .overrun_o     (ovr),
        .timeout_o     (tmo),
        .start_count_o (cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic ct, input logic sg,
                       input int h, input int g, input logic d,
                       input logic cl, input logic s, input logic b,
                       input logic o, input int c);
        vec_t v;
        v.en = e; v.cont = ct; v.single = sg; v.done = d; v.clr = cl;
        v.hc = W'(h); v.gc = W'(g);
        v.s = s; v.b = b; v.o = o; v.c = W'(c);
        vecs.push_back(v);
    endtask

    task automatic pop_cmp();
        exp_t e;
        string n;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        n = $sformatf("v%0d", e.idx);
        chk({n, "_start"}, int'(start), int'(e.s));
        chk({n, "_busy"}, int'(busy), int'(e.b));
        chk({n, "_ovr"}, int'(ovr), int'(e.o));
        chk({n, "_cnt"}, int'(cnt), int'(e.c));
        chk({n, "_tmo"}, int'(tmo), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] exp_cnt;
        logic         prev;
        int           zc, rises, last;
        logic         ok;

        rst_n = 1'b0;
        en = 0; cont = 0; single = 0; done = 0; clr = 0; hc = 0; gc = 0;
        repeat (2) @(negedge clk);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(cnt), 0);
        rst_n = 1'b1;

        // one-shot, hc=3 gc=2; done in IDLE ignored
        add(1,0,0,3,2,0,0, 0,0,0,0);
        add(1,0,1,3,2,0,0, 1,1,0,1);
        add(1,0,0,3,2,0,0, 1,1,0,1);
        add(1,0,0,3,2,0,0, 1,1,0,1);
        add(1,0,0,3,2,0,0, 0,1,0,1);
        add(1,0,0,3,2,0,0, 0,1,0,1);
        add(1,0,0,3,2,1,0, 0,1,0,1);
        add(1,0,0,3,2,0,0, 0,1,0,1);
        add(1,0,0,3,2,0,0, 0,0,0,1);
        add(1,0,0,3,2,1,0, 0,0,0,1);
        // zero clamp
        add(1,0,1,0,0,0,0, 1,1,0,2);
        add(1,0,0,0,0,0,0, 0,1,0,2);
        add(1,0,0,0,0,1,0, 0,1,0,2);
        add(1,0,0,0,0,0,0, 0,0,0,2);
        // overrun, clear vs set in one cycle, pending start
        add(1,0,1,4,1,0,0, 1,1,0,3);
        add(1,0,1,4,1,0,0, 1,1,0,3);
        add(1,0,1,4,1,0,0, 1,1,1,3);
        add(1,0,1,4,1,0,1, 1,1,1,3);
        add(1,0,0,4,1,0,0, 0,1,1,3);
        add(1,0,0,4,1,1,0, 0,1,1,3);
        add(1,0,0,4,1,0,0, 1,1,1,4);
        add(1,0,0,4,1,0,0, 1,1,1,4);
        add(1,0,0,4,1,0,0, 1,1,1,4);
        add(1,0,0,4,1,0,0, 1,1,1,4);
        add(1,0,0,4,1,0,0, 0,1,1,4);
        add(1,0,0,4,1,1,0, 0,1,1,4);
        add(1,0,0,4,1,0,0, 0,0,1,4);
        add(1,0,0,4,1,0,1, 0,0,0,4);
        // abort mid-HIGH drops the pending request
        add(1,0,1,5,1,0,0, 1,1,0,5);
        add(1,0,1,5,1,0,0, 1,1,0,5);
        add(0,0,0,5,1,0,0, 0,0,0,5);
        add(1,0,0,5,1,0,0, 0,0,0,5);
        add(1,0,0,5,1,0,0, 0,0,0,5);
        // done latched while HIGH
        add(1,0,1,2,1,0,0, 1,1,0,6);
        add(1,0,0,2,1,1,0, 1,1,0,6);
        add(1,0,0,2,1,0,0, 0,1,0,6);
        add(1,0,0,2,1,0,0, 0,1,0,6);
        add(1,0,0,2,1,0,0, 0,0,0,6);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge clk);
            if (i > 0) pop_cmp();
            en = vecs[i].en; cont = vecs[i].cont; single = vecs[i].single;
            done = vecs[i].done; clr = vecs[i].clr;
            hc = vecs[i].hc; gc = vecs[i].gc;
            e.idx = i; e.s = vecs[i].s; e.b = vecs[i].b;
            e.o = vecs[i].o; e.c = vecs[i].c;
            sb.push_back(e);
        end
        @(negedge clk);
        pop_cmp();
        single = 0; done = 0; clr = 0;
        exp_cnt = 4'd6;

        // free-running: done in the 6th WAIT_DONE cycle -> period 2+6+5
        en = 1; cont = 1; hc = 4'd2; gc = 4'd5;
        prev = start; zc = 0; rises = 0; last = 0;
        for (int c = 1; c <= 400 && rises < 18; c++) begin
            @(negedge clk);
            if (start && !prev) begin
                rises++;
                exp_cnt = exp_cnt + 4'd1;
                chk("fr_count", int'(cnt), int'(exp_cnt));
                if (rises > 1) chk("fr_period", c - last, 13);
                last = c;
            end
            prev = start;
            zc = start ? 0 : zc + 1;
            done = (zc == 6);
        end
        chk("fr_rises", rises, 18);
        cont = 0; ok = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            zc = start ? 0 : zc + 1;
            done = (zc == 6);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        done = 0;
        chk("fr_stop", int'(ok), 1);
        chk("fr_final_cnt", int'(cnt), int'(exp_cnt));

        // reset while in WAIT_DONE
        hc = 4'd1; gc = 4'd1; single = 1;
        @(negedge clk);
        single = 0;
        @(negedge clk);
        chk("rw_wait_busy", int'(busy), 1);
        chk("rw_wait_start", int'(start), 0);
        rst_n = 0;
        #1;
        chk("rw_start", int'(start), 0);
        chk("rw_busy", int'(busy), 0);
        chk("rw_ovr", int'(ovr), 0);
        chk("rw_tmo", int'(tmo), 0);
        chk("rw_cnt", int'(cnt), 0);
        @(negedge clk);
        rst_n = 1;

        // no done: timeout after 16 WAIT_DONE cycles when built in
        single = 1;
        @(negedge clk);
        single = 0;
        chk("to_start", int'(start), 1);
        repeat (16) @(negedge clk);
        chk("to_pre_tmo", int'(tmo), 0);
        chk("to_pre_busy", int'(busy), 1);
        @(negedge clk);
`ifdef ADC_EDGE_START_TIMEOUT_EN
        chk("to_tmo", int'(tmo), 1);
        chk("to_gap_busy", int'(busy), 1);
        @(negedge clk);
        chk("to_idle", int'(busy), 0);
        clr = 1;
        @(negedge clk);
        clr = 0;
        chk("to_clear", int'(tmo), 0);
`else
        chk("to_tmo", int'(tmo), 0);
        chk("to_still_wait", int'(busy), 1);
        done = 1;
        @(negedge clk);
        done = 0;
        chk("to_gap_busy", int'(busy), 1);
        @(negedge clk);
        chk("to_idle", int'(busy), 0);
`endif
        chk("to_cnt", int'(cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
